mul_iter: RTL and testbench

Sequential multiply/multiply-accumulate engine that produces the 40-bit multiplier result register (MR) consumed by the multiplier rounding stage. It accepts two SIZE-bit operands and a start pulse, iterates one partial-product bit per cycle, then writes, adds or subtracts the product into MR. MR drives `mul40_out_data`, which is the rounding stage's data input.

---
 rtl/mul_iter_if.sv | 27 ++
 rtl/mul_iter.sv | 123 ++++++++++++
 tb/tb_mul_iter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mul_iter_if.sv
// Handshake and data bundle between the multiplier engine and its requester.
// The master drives the operation request and the slave returns MR and status.
interface mul_iter_if #(
  parameter int unsigned SIZE = 16
);
  logic                    mul_start;
  logic [1:0]              mul_op;
  logic                    mul_sgnx;
  logic                    mul_sgny;
  logic                    ps_mul_IbF;
  logic [SIZE-1:0]         x;
  logic [SIZE-1:0]         y;
  logic [SIZE*5/2-1:0]     mul40_out_data;
  logic                    mul_busy;
  logic                    mul_done;
  logic                    mul_ovf;

  modport master (
    output mul_start, mul_op, mul_sgnx, mul_sgny, ps_mul_IbF, x, y,
    input  mul40_out_data, mul_busy, mul_done, mul_ovf
  );

  modport slave (
    input  mul_start, mul_op, mul_sgnx, mul_sgny, ps_mul_IbF, x, y,
    output mul40_out_data, mul_busy, mul_done, mul_ovf
  );
endinterface

// File: rtl/mul_iter.sv
// Sequential shift-add multiply / multiply-accumulate engine producing the MR register
// consumed by the rounding stage. One multiplier bit is retired per CALC cycle.
module mul_iter #(
  parameter int unsigned SIZE = 16
) (
  input logic       clk,
  input logic       reset,
  mul_iter_if.slave bus
);
  localparam int unsigned PW = 2 * SIZE + 1;
  localparam int unsigned MW = SIZE * 5 / 2;
  localparam int unsigned CW = $clog2(SIZE);

  localparam logic [1:0] OpMul  = 2'b00;
  localparam logic [1:0] OpMac  = 2'b01;
  localparam logic [1:0] OpMsub = 2'b10;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   acc_q;
  logic [SIZE-1:0] mplier_q;
  logic [1:0]      op_q;
  logic            sgny_q;
  logic            frac_q;
  logic [MW-1:0]   mr_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  logic            last;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_d;
  logic [MW-1:0]   p_ext;
  logic [MW-1:0]   p_full;
  logic [MW-1:0]   sum;
  logic [MW-1:0]   diff;
  logic [MW-1:0]   mr_d;
  logic            ovf_d;

  assign last = (cnt_q == CW'(SIZE - 1));

  always_comb begin
    pp     = mplier_q[0] ? mcand_q : '0;
    // A signed multiplier's top bit carries negative weight.
    acc_d  = (last && sgny_q) ? acc_q - pp : acc_q + pp;
    p_ext  = {{(MW - PW){acc_d[PW-1]}}, acc_d};
    p_full = frac_q ? {p_ext[MW-2:0], 1'b0} : p_ext;
    sum    = mr_q + p_full;
    diff   = mr_q - p_full;
    mr_d   = '0;
    ovf_d  = 1'b0;
    case (op_q)
      OpMul:  mr_d = p_full;
      OpMac: begin
        mr_d  = sum;
        ovf_d = (mr_q[MW-1] == p_full[MW-1]) && (sum[MW-1] != mr_q[MW-1]);
      end
      OpMsub: begin
        mr_d  = diff;
        ovf_d = (mr_q[MW-1] != p_full[MW-1]) && (diff[MW-1] != mr_q[MW-1]);
      end
      default: mr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mr_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.mul_start) begin
            mcand_q  <= {{(PW - SIZE){bus.mul_sgnx & bus.x[SIZE-1]}}, bus.x};
            mplier_q <= bus.y;
            op_q     <= bus.mul_op;
            sgny_q   <= bus.mul_sgny;
            frac_q   <= bus.ps_mul_IbF;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            mr_q    <= mr_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mul40_out_data = mr_q;
  assign bus.mul_ovf        = ovf_q;
  assign bus.mul_busy       = busy_q;
  assign bus.mul_done       = done_q;
endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: vector table for MUL/MAC/MSUB results plus hand-written
// sequences for overflow, CLR, ignored starts and mid-operation reset.
module tb_mul_iter;
  localparam int unsigned SIZE = 16;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sx;
    logic        sy;
    logic        fr;
    logic [15:0] xv;
    logic [15:0] yv;
    logic [39:0] mr;
    logic        ovf;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mul_iter_if #(.SIZE(SIZE)) bus ();

  mul_iter #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one op from IDLE, tracks busy/done timing, and leaves the DUT back in IDLE.
  task automatic do_op(input vec_t v, input bit chk, input bit inject);
    logic [39:0] mr0;
    int          done_at;
    bit          busy_ok;
    bit          hold_ok;
    mr0 = bus.mul40_out_data;
    bus.mul_op     = v.op;
    bus.mul_sgnx   = v.sx;
    bus.mul_sgny   = v.sy;
    bus.ps_mul_IbF = v.fr;
    bus.x          = v.xv;
    bus.y          = v.yv;
    bus.mul_start  = 1'b1;
    @(posedge clk); #1;
    bus.mul_start  = 1'b0;
    bus.mul_op     = 2'b11;
    bus.mul_sgnx   = ~v.sx;
    bus.mul_sgny   = ~v.sy;
    bus.ps_mul_IbF = ~v.fr;
    bus.x          = 16'hA5C3;
    bus.y          = 16'h3C5A;
    done_at = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.mul_done) begin
        done_at = n;
        if (bus.mul_busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.mul_busy) busy_ok = 1'b0;
      if (bus.mul40_out_data !== mr0) hold_ok = 1'b0;
      bus.mul_start = inject && (n == 5);
      @(posedge clk); #1;
    end
    bus.mul_start = 1'b0;
    if (chk) begin
      check({v.name, " latency"}, 40'(done_at), 40'd17);
      check({v.name, " busy"}, {39'd0, busy_ok}, 40'd1);
      check({v.name, " hold"}, {39'd0, hold_ok}, 40'd1);
      check({v.name, " mr"}, bus.mul40_out_data, v.mr);
      check({v.name, " ovf"}, {39'd0, bus.mul_ovf}, {39'd0, v.ovf});
    end
    bus.mul_start = inject;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    if (chk && inject) begin
      @(posedge clk); #1;
      check({v.name, " start in done ignored"}, {38'd0, bus.mul_busy, bus.mul_done}, 40'd0);
      check({v.name, " mr after ignored start"}, bus.mul40_out_data, v.mr);
    end
  endtask

  vec_t vecs[9];
  vec_t v;
  bit   idle_ok;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.mul_start  = 1'b0;
    bus.mul_op     = 2'b00;
    bus.mul_sgnx   = 1'b0;
    bus.mul_sgny   = 1'b0;
    bus.ps_mul_IbF = 1'b0;
    bus.x          = '0;
    bus.y          = '0;

    vecs[0] = '{"mul 3x5",        2'b00, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005, 40'h00_0000_000F, 1'b0};
    vecs[1] = '{"mul ss -1x-1",   2'b00, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 40'h00_0000_0001, 1'b0};
    vecs[2] = '{"mul uu ffff",    2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 40'h00_FFFE_0001, 1'b0};
    vecs[3] = '{"mul su ffff",    2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 40'hFF_FFFF_0001, 1'b0};
    vecs[4] = '{"frac 4000",      2'b00, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h4000, 40'h00_2000_0000, 1'b0};
    vecs[5] = '{"frac 8000",      2'b00, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000, 40'h00_8000_0000, 1'b0};
    vecs[6] = '{"chain mul 2x3",  2'b00, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0003, 40'h00_0000_0006, 1'b0};
    vecs[7] = '{"chain mac 4x5",  2'b01, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0005, 40'h00_0000_001A, 1'b0};
    vecs[8] = '{"chain msub 1x1", 2'b10, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 40'h00_0000_0019, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset mr", bus.mul40_out_data, 40'd0);
    check("reset flags", {37'd0, bus.mul_busy, bus.mul_done, bus.mul_ovf}, 40'd0);
    reset = 1'b1;
    idle_ok = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.mul_busy || bus.mul_done || bus.mul_ovf || bus.mul40_out_data !== 40'd0)
        idle_ok = 1'b0;
    end
    check("idle 50 cycles", {39'd0, idle_ok}, 40'd1);

    for (int i = 0; i < 9; i++) do_op(vecs[i], 1'b1, 1'b0);

    // Build MR up to 2^39 with 2^31 steps; the last MAC crosses into bit 39.
    v = '{"pre mul", 2'b00, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000, 40'h00_8000_0000, 1'b0};
    do_op(v, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) begin
      v = '{"pre mac", 2'b01, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000, 40'h80_0000_0000, 1'b1};
      do_op(v, i == 254, 1'b0);
    end
    v = '{"msub to 7fff", 2'b10, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 40'h7F_FFFF_FFFF, 1'b1};
    do_op(v, 1'b1, 1'b0);
    v = '{"mac ovf", 2'b01, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 40'h80_0000_0000, 1'b1};
    do_op(v, 1'b1, 1'b0);
    v = '{"mul clears ovf", 2'b00, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005, 40'h00_0000_000F, 1'b0};
    do_op(v, 1'b1, 1'b0);
    v = '{"clr", 2'b11, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, 40'h00_0000_0000, 1'b0};
    do_op(v, 1'b1, 1'b0);

    v = '{"inject 7x9", 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0009, 40'h00_0000_003F, 1'b0};
    do_op(v, 1'b1, 1'b1);

    v = '{"mr 1a", 2'b00, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h000D, 40'h00_0000_001A, 1'b0};
    do_op(v, 1'b1, 1'b0);
    bus.mul_op     = 2'b00;
    bus.mul_sgnx   = 1'b1;
    bus.mul_sgny   = 1'b1;
    bus.ps_mul_IbF = 1'b0;
    bus.x          = 16'h0003;
    bus.y          = 16'h0005;
    bus.mul_start  = 1'b1;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy before reset", {39'd0, bus.mul_busy}, 40'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midcalc reset mr", bus.mul40_out_data, 40'd0);
    check("midcalc reset flags", {37'd0, bus.mul_busy, bus.mul_done, bus.mul_ovf}, 40'd0);
    reset = 1'b1;
    idle_ok = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.mul_busy || bus.mul_done) idle_ok = 1'b0;
    end
    check("no done after reset", {39'd0, idle_ok}, 40'd1);
    v = '{"after reset 3x5", 2'b00, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005, 40'h00_0000_000F, 1'b0};
    do_op(v, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
